// File: rtl/gpio_in.sv
// rtl/gpio_in.sv - debounced GPIO input port with sticky edge flags, IRQ and registered read
module gpio_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] A_LEVEL  = 2'd0;
    localparam logic [1:0] A_RISE   = 2'd1;
    localparam logic [1:0] A_FALL   = 2'd2;
    localparam logic [1:0] A_IRQ_EN = 2'd3;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] irq_en;
    logic [CW-1:0]    cnt [WIDTH];

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise_set;
    logic [WIDTH-1:0] fall_set;
    logic [WIDTH-1:0] rise_clr;
    logic [WIDTH-1:0] fall_clr;
    logic [31:0]      rd_val;

    // Two-flop synchroniser for the raw switch levels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // A bit flips once it has disagreed with the stable level for DEBOUNCE_CYCLES edges
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    assign rise_set = accept & s2;
    assign fall_set = accept & ~s2;

    // Per-bit debounce counters and the accepted stable levels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            stable <= stable ^ accept;
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == stable[i] || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Write-one-to-clear masks for the sticky edge flags
    assign rise_clr = (wr_en && addr == A_RISE) ? wdata : '0;
    assign fall_clr = (wr_en && addr == A_FALL) ? wdata : '0;

    // Sticky edge flags (a new edge beats a clear in the same cycle) and interrupt enables
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rise   <= '0;
            fall   <= '0;
            irq_en <= '0;
        end else begin
            rise <= (rise & ~rise_clr) | rise_set;
            fall <= (fall & ~fall_clr) | fall_set;
            if (wr_en && addr == A_IRQ_EN) begin
                irq_en <= wdata;
            end
        end
    end

    // Register select for the read port, zero-extended to 32 bits
    always_comb begin
        rd_val = '0;
        case (addr)
            A_LEVEL:  rd_val[WIDTH-1:0] = stable;
            A_RISE:   rd_val[WIDTH-1:0] = rise;
            A_FALL:   rd_val[WIDTH-1:0] = fall;
            A_IRQ_EN: rd_val[WIDTH-1:0] = irq_en;
            default:  rd_val = '0;
        endcase
    end

    // Registered read data, held while no read is in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_val;
        end
    end

    assign irq = |((rise | fall) & irq_en);

endmodule
